// File: rtl/arb_client_pkg.sv
// Shared definitions for the arbiter client adapter: FSM encodings, the default
// RAM channel widths used by the arbiter, and its watchdog limit.
package arb_client_pkg;

  typedef enum logic [1:0] {
    stIDLE  = 2'b00,
    stREQ   = 2'b01,
    stYIELD = 2'b10
  } state_t;

  localparam int unsigned ARB_ADDR_WIDTH = 12;
  localparam int unsigned ARB_DATA_WIDTH = 8;
  localparam int unsigned WD_LIMIT       = 63;

  // A burst must end before the arbiter watchdog reclaims the grant.
  function automatic logic burst_in_range(input int unsigned max_burst);
    return (max_burst >= 32'd1) && (max_burst < WD_LIMIT);
  endfunction

  function automatic logic depth_is_pow2(input int unsigned depth);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// Command FIFO for the arbiter client: synchronous, power-of-two depth,
// combinational head output, pushes and pops are qualified internally.
module arb_client_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array and write pointer; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arb_client.sv
// Requester-side adapter for one channel of the round-robin RAM arbiter:
// queues master commands, drives the channel, bounds bursts, returns responses.
module arb_client
  import arb_client_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wrdata,
  input  logic                  cmd_rdwrn,
  output logic                  req,
  input  logic                  ack,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic                  rdWrn,
  input  logic [DATA_WIDTH-1:0] rddata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  wr_done,
  output logic                  err_ack
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH + 1;

  if (!burst_in_range(MAX_BURST)) begin : g_bad_burst
    $error("arb_client: MAX_BURST must be in 1..62");
  end
  if (!depth_is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("arb_client: FIFO_DEPTH must be a power of two, at least 2");
  end

  state_t                r_state;
  logic [BW-1:0]         r_burst;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_wr_done;
  logic                  r_err_ack;

  logic [EW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_push;
  logic                  w_req;
  logic                  w_retire;
  logic                  w_last_beat;
  logic                  w_will_empty;

  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;

  arb_client_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_retire),
    .i_data  ({cmd_addr, cmd_wrdata, cmd_rdwrn}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Channel fields come straight from the head, so they only move on a pop.
  assign {address, wrdata, rdWrn} = w_head;

  assign w_req        = (r_state == stREQ) && !w_empty;
  assign w_retire     = w_req && ack;
  assign w_last_beat  = (r_burst == BW'(MAX_BURST - 1));
  assign w_will_empty = (w_count == CW'(1)) && !w_push;

  assign req       = w_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign wr_done   = r_wr_done;
  assign err_ack   = r_err_ack;

  // Grant FSM: request while work is queued, yield after a full burst or drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= stIDLE;
      r_burst <= '0;
    end else begin
      case (r_state)
        stIDLE: begin
          r_burst <= '0;
          if (!w_empty) begin
            r_state <= stREQ;
          end
        end
        stREQ: begin
          // A dropped ack simply stalls here with the head held.
          if (w_retire) begin
            r_burst <= r_burst + BW'(1);
            if (w_last_beat || w_will_empty) begin
              r_state <= stYIELD;
            end
          end
        end
        stYIELD: begin
          r_burst <= '0;
          r_state <= w_empty ? stIDLE : stREQ;
        end
        default: begin
          r_state <= stIDLE;
          r_burst <= '0;
        end
      endcase
    end
  end

  // Response pulses; read data is captured on the retiring edge and held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_wr_done   <= 1'b0;
    end else begin
      r_rsp_valid <= w_retire && rdWrn;
      r_wr_done   <= w_retire && !rdWrn;
      if (w_retire && rdWrn) begin
        r_rsp_data <= rddata;
      end
    end
  end

  // Sticky protocol error: the arbiter acked a channel that was not requesting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_ack <= 1'b0;
    end else if (ack && !w_req) begin
      r_err_ack <= 1'b1;
    end
  end

endmodule
